// File: rtl/countdown_sched.sv
// Countdown-timer controller: loads a seconds value, runs it down one second
// per CLK_PER_TICK clocks, and reports ticks, expiry and run/pause status.
//
// Handshake / control semantics: start, pause and clear are plain level inputs
// sampled on every rising clk edge; there is no valid/ready pairing. Per cycle
// the priority is clear > terminal count (tick/done) > pause > start. Every
// output is a flop, so nothing here is combinational from input to output.
module countdown_sched #(
  parameter int CLK_PER_TICK = 50_000_000,
  parameter int SEC_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [SEC_W-1:0] load_sec,
  output logic [SEC_W-1:0] sec_left,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_PER_TICK - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t           cur_state, nxt_state;
  logic [PW-1:0]    pre, nxt_pre;
  logic [SEC_W-1:0] nxt_sec;
  logic             nxt_tick, nxt_done;
  logic             terminal;

  // Terminal count only matters while actually running.
  assign terminal = (cur_state == S_RUN) && (pre == PRE_MAX);

  // State and datapath registers; everything visible outside is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state <= S_IDLE;
      pre       <= '0;
      sec_left  <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      pre       <= nxt_pre;
      sec_left  <= nxt_sec;
      tick      <= nxt_tick;
      done      <= nxt_done;
      busy      <= (nxt_state == S_RUN) || (nxt_state == S_PAUSE);
    end
  end

  // Next-state decision following the clear > expiry > pause > start order.
  always_comb begin
    nxt_state = cur_state;
    if (clear) begin
      nxt_state = S_IDLE;
    end else begin
      case (cur_state)
        S_IDLE, S_DONE: begin
          if (start) nxt_state = (load_sec != '0) ? S_RUN : S_DONE;
        end
        S_RUN: begin
          if (terminal && (sec_left == SEC_W'(1))) nxt_state = S_DONE;
          else if (pause)                          nxt_state = S_PAUSE;
        end
        S_PAUSE: begin
          if (start) nxt_state = S_RUN;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Next values of prescaler, seconds count and the one-cycle pulses.
  always_comb begin
    nxt_pre  = pre;
    nxt_sec  = sec_left;
    nxt_tick = 1'b0;
    nxt_done = 1'b0;
    if (clear) begin
      nxt_pre = '0;
      nxt_sec = '0;
    end else begin
      case (cur_state)
        S_IDLE, S_DONE: begin
          nxt_pre = '0;
          nxt_sec = '0;
          if (start) begin
            nxt_sec  = load_sec;
            nxt_done = (load_sec == '0);
          end
        end
        S_RUN: begin
          if (terminal) begin
            nxt_pre  = '0;
            nxt_tick = 1'b1;
            if (sec_left != '0) nxt_sec = sec_left - SEC_W'(1);
            nxt_done = (sec_left == SEC_W'(1));
          end else if (!pause) begin
            nxt_pre = pre + PW'(1);
          end
        end
        default: begin
          // PAUSE holds prescaler and seconds until resumed or cleared.
        end
      endcase
    end
  end

  assign state = cur_state;

endmodule
